mpf_svc_vtp_l1_miss_handler: RTL and testbench
==============================================

Name: mpf_svc_vtp_l1_miss_handler

Overview:
Consumes the output FIFO of the per-port L1 VTP lookup stage. L1 hits pass straight through to the downstream channel. An L1 miss is forwarded to the shared VTP TLB service. The translation that comes back is inserted into the L1 caches and returned downstream. Misses are blocking and responses stay in order, so there is at most one outstanding shared-TLB request per port.

Parameters:
N_OPAQUE_BITS, 0, width of opaque state carried with each request
DEBUG_MESSAGES, 0, nonzero enables $display of each miss and fill

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-low reset
lkpNotEmpty  in  1  L1 lookup FIFO has an entry
lkpReq  in  t_mpf_vtp_lookup_req  original request at L1 FIFO head
lkpOpaque  in  N_OPAQUE_BITS  opaque state at L1 FIFO head
lkpRsp  in  t_mpf_vtp_lookup_rsp  L1 result; error=1 means L1 miss
lkpDeq  out  1  pop the L1 FIFO head
tlbReqEn  out  1  request valid to shared TLB service
tlbReq  out  t_mpf_vtp_lookup_req  miss request
tlbReqRdy  in  1  shared TLB accepts the request
tlbRspValid  in  1  shared TLB response valid
tlbRsp  in  t_mpf_vtp_lookup_rsp  shared TLB response
insertVA  out  t_tlb_4kb_va_page_idx  L1 insert VA
insertPA  out  t_tlb_4kb_pa_page_idx  L1 insert PA
en_insert_4kb  out  1  one-cycle insert strobe, 4KB cache
en_insert_2mb  out  1  one-cycle insert strobe, 2MB cache
outValid  out  1  downstream response valid
outReq  out  t_mpf_vtp_lookup_req  original request
outOpaque  out  N_OPAQUE_BITS  opaque state
outRsp  out  t_mpf_vtp_lookup_rsp  final translation
outRdy  in  1  downstream accepts the response
statHits, statMisses, statFaults  out  32 each  wrapping event counters

Behaviour:
- FSM states: IDLE, MISS_REQ, MISS_WAIT, MISS_OUT. Reset (reset_n=0 at a clk edge) sets:
  - state to IDLE;
  - outValid, tlbReqEn, en_insert_* and all stat counters to 0;
  - the data registers to don't-care.
- Output register: a single entry. It is "free" when !outValid || outRdy. outValid holds until outRdy is sampled high.
- IDLE, hit:
  - Condition: lkpNotEmpty && !lkpRsp.error.
  - If the output register is free: lkpDeq=1 combinationally. The output register loads {lkpReq, lkpOpaque, lkpRsp} next cycle, with outRsp.tag=lkpReq.tag and mayCache=1. statHits increments.
  - Latency from FIFO head to outValid is 1 cycle. Back-to-back hits sustain 1 per cycle while outRdy=1.
- IDLE, miss:
  - Condition: lkpNotEmpty && lkpRsp.error.
  - lkpDeq=1. Req and opaque are latched into the miss buffer. statMisses increments. Go to MISS_REQ.
  - The output register does not need to be free to take a miss.
- MISS_REQ:
  - tlbReqEn=1 and tlbReq=miss buffer request.
  - On tlbReqRdy: go to MISS_WAIT. tlbReqEn drops the next cycle.
- MISS_WAIT:
  - lkpDeq=0.
  - On tlbRspValid: latch tlbRsp and go to MISS_OUT.
  - In the same cycle, register the insert: insertVA=miss pageVA, insertPA=tlbRsp.pagePA.
  - The insert fires only if tlbRsp.error==0 and tlbRsp.mayCache==1. It strobes en_insert_2mb when tlbRsp.isBigPage, otherwise en_insert_4kb, for exactly one cycle, the cycle after tlbRspValid.
  - If tlbRsp.error==1: no insert, statFaults increments, and the error is passed downstream.
- MISS_OUT:
  - When the output register is free, load {miss req, miss opaque, latched tlbRsp}. outRsp.tag=miss req tag. mayCache is taken from tlbRsp.
  - Then go to IDLE. The earliest next lkpDeq is the cycle after this load.
- Ordering: lkpDeq is never asserted outside IDLE, so responses leave in FIFO order.
- Inserting into L1 while entries already in the L1 FIFO carry stale misses is legal. Those entries simply miss again.
- tlbRspValid outside MISS_WAIT is ignored. DEBUG_MESSAGES reports it.
- Reset mid-miss: everything is abandoned, including the outstanding request. The shared service must be reset together with this block.
- Counters wrap at 2^32.
- en_insert_4kb and en_insert_2mb are never both 1.

Decomposition:
- t_mpf_vtp_lookup_req, t_mpf_vtp_lookup_rsp, t_tlb_4kb_va_page_idx and t_tlb_4kb_pa_page_idx come from the existing mpf_vtp package/header.
- Add to the same package:
  - t_mpf_vtp_l1_miss_state, the FSM enum;
  - a struct bundling {req, opaque, rsp} for the output register.
- No sub-module. The output register and FSM are in one file, roughly 200 lines.

Test Plan:
- Hit stream: 8 entries with error=0 and outRdy=1 -> 8 outValid pulses on consecutive cycles, each 1 cycle after its lkpDeq; statHits=8; no tlbReqEn.
- Miss 4KB:
  - Stimulus: pageVA=0x12345, error=1; tlbReqRdy after 3 cycles; tlbRsp{pagePA=0x0ABCD, isBigPage=0, mayCache=1} 10 cycles later.
  - Response: tlbReq.pageVA=0x12345; en_insert_4kb pulses once with insertVA=0x12345 and insertPA=0x0ABCD; outRsp.pagePA=0x0ABCD; statMisses=1.
- Miss 2MB, with mayCache=0 variant:
  - isBigPage=1 -> en_insert_2mb only.
  - mayCache=0 -> no insert strobe, but the response is still delivered.
- Fault: tlbRsp.error=1 -> no insert, outRsp.error=1, statFaults=1.
- Ordering/backpressure:
  - Stimulus: hit, miss, hit queued; outRdy=0 for 20 cycles.
  - Response: outputs in order hit, miss, hit; outValid stable while stalled; second hit not dequeued until the miss leaves.
- Reset during MISS_WAIT: reset_n=0 for 1 cycle -> next cycle outValid=0, tlbReqEn=0, counters=0; a late tlbRspValid produces no insert and no output.

Source files
------------

// File: rtl/mpf_svc_vtp_l1_miss_handler_pkg.sv
// Shared types for the per-port L1 VTP miss handler.
//
// The lookup request and response types mirror the wider mpf_vtp type set.
// They are collected here so the handler and its bench compile on their own.
// The handler adds two types: its FSM state enum and the output-register
// entry struct.
package mpf_svc_vtp_l1_miss_handler_pkg;

  localparam int VA_PAGE_BITS    = 36;  // 48-bit VA, 4KB pages
  localparam int PA_PAGE_BITS    = 28;  // 40-bit PA, 4KB pages
  localparam int TAG_BITS        = 8;
  // Widest opaque payload the output-register entry can carry.
  localparam int MAX_OPAQUE_BITS = 64;

  typedef logic [VA_PAGE_BITS-1:0]    t_tlb_4kb_va_page_idx;
  typedef logic [PA_PAGE_BITS-1:0]    t_tlb_4kb_pa_page_idx;
  typedef logic [TAG_BITS-1:0]        t_mpf_vtp_tag;
  typedef logic [MAX_OPAQUE_BITS-1:0] t_mpf_vtp_opaque;

  typedef struct packed {
    t_tlb_4kb_va_page_idx pageVA;
    logic                 isSpeculative;
    t_mpf_vtp_tag         tag;
  } t_mpf_vtp_lookup_req;

  typedef struct packed {
    t_tlb_4kb_pa_page_idx pagePA;
    t_mpf_vtp_tag         tag;
    logic                 error;      // L1: miss.  Shared TLB: translation fault.
    logic                 isBigPage;
    logic                 mayCache;
  } t_mpf_vtp_lookup_rsp;

  typedef enum logic [1:0] {
    IDLE,
    MISS_REQ,
    MISS_WAIT,
    MISS_OUT
  } t_mpf_vtp_l1_miss_state;

  // One downstream response. The opaque field is sized for the widest
  // payload. The handler zero-extends into it and slices back out.
  typedef struct packed {
    t_mpf_vtp_lookup_req req;
    t_mpf_vtp_opaque     opaque;
    t_mpf_vtp_lookup_rsp rsp;
  } t_mpf_vtp_l1_out_entry;

  // Responses always carry the tag of the original request. The mayCache
  // flag is chosen by the path that produced the translation.
  function automatic t_mpf_vtp_lookup_rsp retag_rsp(
    input t_mpf_vtp_lookup_rsp rsp,
    input t_mpf_vtp_tag        tag,
    input logic                may_cache
  );
    t_mpf_vtp_lookup_rsp r;
    r          = rsp;
    r.tag      = tag;
    r.mayCache = may_cache;
    return r;
  endfunction

endpackage

// File: rtl/mpf_svc_vtp_l1_miss_handler.sv
// Per-port L1 VTP miss handler.
//
// This block drains the L1 lookup FIFO.
// - Hits are copied to the downstream output register.
// - A miss is sent to the shared TLB service, and the block blocks until
//   the translation returns.
// - A good cacheable translation is inserted into the L1 cache that
//   matches its page size. The translation is then returned downstream.
// Only one miss is outstanding at a time, so responses leave in FIFO order.
//
// Ports:
//   clk, reset_n                    clock, synchronous active-low reset
//   lkpNotEmpty/lkpReq/lkpOpaque/
//   lkpRsp, lkpDeq                  L1 lookup FIFO head and pop
//   tlbReqEn/tlbReq/tlbReqRdy       request to the shared TLB service
//   tlbRspValid/tlbRsp              response from the shared TLB service
//   insertVA/insertPA,
//   en_insert_4kb/en_insert_2mb     one-cycle L1 fill strobes
//   outValid/outReq/outOpaque/
//   outRsp/outRdy                   downstream response channel
//   statHits/statMisses/statFaults  wrapping 32-bit event counters
//
// N_OPAQUE_BITS must not exceed MAX_OPAQUE_BITS. A value of 0 still gives
// a 1-bit opaque port.
module mpf_svc_vtp_l1_miss_handler
  import mpf_svc_vtp_l1_miss_handler_pkg::*;
#(
  parameter  int N_OPAQUE_BITS  = 0,
  parameter  int DEBUG_MESSAGES = 0,
  localparam int OPAQUE_W       = (N_OPAQUE_BITS > 0) ? N_OPAQUE_BITS : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,

  input  logic                  lkpNotEmpty,
  input  t_mpf_vtp_lookup_req   lkpReq,
  input  logic [OPAQUE_W-1:0]   lkpOpaque,
  input  t_mpf_vtp_lookup_rsp   lkpRsp,
  output logic                  lkpDeq,

  output logic                  tlbReqEn,
  output t_mpf_vtp_lookup_req   tlbReq,
  input  logic                  tlbReqRdy,
  input  logic                  tlbRspValid,
  input  t_mpf_vtp_lookup_rsp   tlbRsp,

  output t_tlb_4kb_va_page_idx  insertVA,
  output t_tlb_4kb_pa_page_idx  insertPA,
  output logic                  en_insert_4kb,
  output logic                  en_insert_2mb,

  output logic                  outValid,
  output t_mpf_vtp_lookup_req   outReq,
  output logic [OPAQUE_W-1:0]   outOpaque,
  output t_mpf_vtp_lookup_rsp   outRsp,
  input  logic                  outRdy,

  output logic [31:0]           statHits,
  output logic [31:0]           statMisses,
  output logic [31:0]           statFaults
);

  // Miss/fill tracing is a simulation aid. It stays outside this
  // synthesizable source, so the parameter is accepted but unused here.
  localparam bit unused_debug_messages = (DEBUG_MESSAGES != 0);

  t_mpf_vtp_l1_miss_state state_q, state_d;

  logic                  out_valid_q;
  t_mpf_vtp_l1_out_entry out_q;

  t_mpf_vtp_lookup_req   miss_req_q;
  logic [OPAQUE_W-1:0]   miss_opaque_q;
  t_mpf_vtp_lookup_rsp   miss_rsp_q;

  t_tlb_4kb_va_page_idx  insert_va_q;
  t_tlb_4kb_pa_page_idx  insert_pa_q;
  logic                  en_4kb_q, en_2mb_q;

  logic [31:0]           stat_hits_q, stat_misses_q, stat_faults_q;

  logic out_free;
  logic take_hit, take_miss, take_rsp, load_miss_out;
  logic insert_ok;

  // The output register can accept new data when it is empty, or when its
  // current entry is being consumed this cycle.
  assign out_free  = !out_valid_q || outRdy;
  assign insert_ok = !tlbRsp.error && tlbRsp.mayCache;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state and control decode
  // ---------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_d       = state_q;
    lkpDeq        = 1'b0;
    tlbReqEn      = 1'b0;
    take_hit      = 1'b0;
    take_miss     = 1'b0;
    take_rsp      = 1'b0;
    load_miss_out = 1'b0;

    case (state_q)
      IDLE: begin
        if (lkpNotEmpty) begin
          if (lkpRsp.error) begin
            // A miss waits in the miss buffer, not in the output
            // register, so the output register does not need to be free.
            lkpDeq    = 1'b1;
            take_miss = 1'b1;
            state_d   = MISS_REQ;
          end else if (out_free) begin
            lkpDeq    = 1'b1;
            take_hit  = 1'b1;
          end
        end
      end

      MISS_REQ: begin
        tlbReqEn = 1'b1;
        if (tlbReqRdy) begin
          state_d = MISS_WAIT;
        end
      end

      MISS_WAIT: begin
        if (tlbRspValid) begin
          take_rsp = 1'b1;
          state_d  = MISS_OUT;
        end
      end

      MISS_OUT: begin
        if (out_free) begin
          load_miss_out = 1'b1;
          state_d       = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Control flops and counters (reset)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q   <= 1'b0;
      en_4kb_q      <= 1'b0;
      en_2mb_q      <= 1'b0;
      stat_hits_q   <= '0;
      stat_misses_q <= '0;
      stat_faults_q <= '0;
    end else begin
      if (take_hit || load_miss_out) begin
        out_valid_q <= 1'b1;
      end else if (outRdy) begin
        out_valid_q <= 1'b0;
      end

      // The size bit selects one cache, so the two strobes are mutually
      // exclusive.
      en_4kb_q <= take_rsp && insert_ok && !tlbRsp.isBigPage;
      en_2mb_q <= take_rsp && insert_ok &&  tlbRsp.isBigPage;

      if (take_hit)                 stat_hits_q   <= stat_hits_q   + 32'd1;
      if (take_miss)                stat_misses_q <= stat_misses_q + 32'd1;
      if (take_rsp && tlbRsp.error) stat_faults_q <= stat_faults_q + 32'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Data registers
  // ---------------------------------------------------------------------
  // NOTE: payload registers have no reset. They are only read while a
  // valid flag or FSM state qualifies them, so their reset value does not
  // matter.
  always_ff @(posedge clk) begin
    if (take_hit) begin
      out_q.req    <= lkpReq;
      out_q.opaque <= t_mpf_vtp_opaque'(lkpOpaque);
      out_q.rsp    <= retag_rsp(lkpRsp, lkpReq.tag, 1'b1);
    end else if (load_miss_out) begin
      out_q.req    <= miss_req_q;
      out_q.opaque <= t_mpf_vtp_opaque'(miss_opaque_q);
      out_q.rsp    <= retag_rsp(miss_rsp_q, miss_req_q.tag, miss_rsp_q.mayCache);
    end

    if (take_miss) begin
      miss_req_q    <= lkpReq;
      miss_opaque_q <= lkpOpaque;
    end

    if (take_rsp) begin
      miss_rsp_q  <= tlbRsp;
      insert_va_q <= miss_req_q.pageVA;
      insert_pa_q <= tlbRsp.pagePA;
    end
  end

  // The upper opaque bits are padding. This reduction marks them as
  // deliberately unread.
  logic unused_opaque_pad;
  assign unused_opaque_pad = ^out_q.opaque;

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign tlbReq        = miss_req_q;

  assign insertVA      = insert_va_q;
  assign insertPA      = insert_pa_q;
  assign en_insert_4kb = en_4kb_q;
  assign en_insert_2mb = en_2mb_q;

  assign outValid      = out_valid_q;
  assign outReq        = out_q.req;
  assign outOpaque     = out_q.opaque[OPAQUE_W-1:0];
  assign outRsp        = out_q.rsp;

  assign statHits      = stat_hits_q;
  assign statMisses    = stat_misses_q;
  assign statFaults    = stat_faults_q;

endmodule

// File: tb/tb_mpf_svc_vtp_l1_miss_handler.sv
// Directed self-checking bench for mpf_svc_vtp_l1_miss_handler.
// A small queue models the L1 lookup FIFO. Each cycle the bench drives
// inputs 2 time units after the rising edge and samples outputs 1 unit
// later.
module tb_mpf_svc_vtp_l1_miss_handler;
  import mpf_svc_vtp_l1_miss_handler_pkg::*;

  localparam int OPQ = 8;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 lkpNotEmpty;
  t_mpf_vtp_lookup_req  lkpReq;
  logic [OPQ-1:0]       lkpOpaque;
  t_mpf_vtp_lookup_rsp  lkpRsp;
  logic                 lkpDeq;
  logic                 tlbReqEn;
  t_mpf_vtp_lookup_req  tlbReq;
  logic                 tlbReqRdy;
  logic                 tlbRspValid;
  t_mpf_vtp_lookup_rsp  tlbRsp;
  t_tlb_4kb_va_page_idx insertVA;
  t_tlb_4kb_pa_page_idx insertPA;
  logic                 en_insert_4kb, en_insert_2mb;
  logic                 outValid;
  t_mpf_vtp_lookup_req  outReq;
  logic [OPQ-1:0]       outOpaque;
  t_mpf_vtp_lookup_rsp  outRsp;
  logic                 outRdy;
  logic [31:0]          statHits, statMisses, statFaults;

  mpf_svc_vtp_l1_miss_handler #(.N_OPAQUE_BITS(OPQ), .DEBUG_MESSAGES(0)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .lkpNotEmpty   (lkpNotEmpty),
    .lkpReq        (lkpReq),
    .lkpOpaque     (lkpOpaque),
    .lkpRsp        (lkpRsp),
    .lkpDeq        (lkpDeq),
    .tlbReqEn      (tlbReqEn),
    .tlbReq        (tlbReq),
    .tlbReqRdy     (tlbReqRdy),
    .tlbRspValid   (tlbRspValid),
    .tlbRsp        (tlbRsp),
    .insertVA      (insertVA),
    .insertPA      (insertPA),
    .en_insert_4kb (en_insert_4kb),
    .en_insert_2mb (en_insert_2mb),
    .outValid      (outValid),
    .outReq        (outReq),
    .outOpaque     (outOpaque),
    .outRsp        (outRsp),
    .outRdy        (outRdy),
    .statHits      (statHits),
    .statMisses    (statMisses),
    .statFaults    (statFaults)
  );

  always #5 clk = ~clk;

  typedef struct {
    t_mpf_vtp_lookup_req req;
    logic [OPQ-1:0]      opq;
    t_mpf_vtp_lookup_rsp rsp;
  } fifo_ent_t;

  fifo_ent_t fifo[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic t_mpf_vtp_lookup_req mk_req(input t_tlb_4kb_va_page_idx va, input logic [7:0] tag);
    t_mpf_vtp_lookup_req r;
    r.pageVA        = va;
    r.isSpeculative = 1'b0;
    r.tag           = tag;
    return r;
  endfunction

  // Response tags are set to 0xFF so that every check of outRsp.tag proves
  // the DUT replaces the tag with the request tag.
  function automatic t_mpf_vtp_lookup_rsp mk_rsp(input t_tlb_4kb_pa_page_idx pa, input logic err,
                                                 input logic big, input logic mc);
    t_mpf_vtp_lookup_rsp r;
    r.pagePA    = pa;
    r.tag       = 8'hFF;
    r.error     = err;
    r.isBigPage = big;
    r.mayCache  = mc;
    return r;
  endfunction

  task automatic drive_head();
    lkpNotEmpty = (fifo.size() != 0);
    if (fifo.size() != 0) begin
      lkpReq    = fifo[0].req;
      lkpOpaque = fifo[0].opq;
      lkpRsp    = fifo[0].rsp;
    end else begin
      lkpReq    = '0;
      lkpOpaque = '0;
      lkpRsp    = '0;
    end
  endtask

  task automatic push(input t_mpf_vtp_lookup_req req, input logic [OPQ-1:0] opq, input t_mpf_vtp_lookup_rsp rsp);
    fifo_ent_t e;
    e.req = req;
    e.opq = opq;
    e.rsp = rsp;
    fifo.push_back(e);
    drive_head();
  endtask

  task automatic settle();
    #1;
  endtask

  // Advance one clock. The FIFO pops when the DUT held lkpDeq before the edge.
  task automatic tick();
    logic deq;
    deq = lkpDeq;
    @(posedge clk);
    #2;
    if (deq && fifo.size() != 0) fifo.delete(0);
    drive_head();
    #1;
  endtask

  // Runs one L1 miss through the handler with the FIFO otherwise empty and
  // outRdy=1. Checks the shared-TLB handshake, the insert strobes and the
  // delivered response.
  task automatic run_miss(input string name, input t_tlb_4kb_va_page_idx va, input logic [7:0] tag,
                          input logic [OPQ-1:0] opq, input t_mpf_vtp_lookup_rsp trsp,
                          input int rdy_wait, input int rsp_wait, input logic exp4, input logic exp2);
    push(mk_req(va, tag), opq, mk_rsp(28'h0, 1'b1, 1'b0, 1'b0));
    settle();
    check({name, ".deq"}, 64'(lkpDeq), 64'd1);
    tick();
    for (int k = 0; k < rdy_wait; k++) begin
      check({name, ".req_en_hold"}, 64'(tlbReqEn), 64'd1);
      tick();
    end
    check({name, ".req_en"}, 64'(tlbReqEn), 64'd1);
    check({name, ".req_va"}, 64'(tlbReq.pageVA), 64'(va));
    tlbReqRdy = 1'b1;
    tick();
    tlbReqRdy = 1'b0;
    check({name, ".req_en_drop"}, 64'(tlbReqEn), 64'd0);
    for (int k = 0; k < rsp_wait; k++) tick();
    check({name, ".wait_no_out"}, 64'(outValid), 64'd0);
    tlbRspValid = 1'b1;
    tlbRsp      = trsp;
    tick();
    tlbRspValid = 1'b0;
    tlbRsp      = '0;
    check({name, ".ins4k"}, 64'(en_insert_4kb), 64'(exp4));
    check({name, ".ins2m"}, 64'(en_insert_2mb), 64'(exp2));
    if (exp4 || exp2) begin
      check({name, ".ins_va"}, 64'(insertVA), 64'(va));
      check({name, ".ins_pa"}, 64'(insertPA), 64'(trsp.pagePA));
    end
    check({name, ".out_not_yet"}, 64'(outValid), 64'd0);
    tick();
    check({name, ".ins_off"}, 64'({en_insert_4kb, en_insert_2mb}), 64'd0);
    check({name, ".out_valid"}, 64'(outValid), 64'd1);
    check({name, ".out_va"}, 64'(outReq.pageVA), 64'(va));
    check({name, ".out_opq"}, 64'(outOpaque), 64'(opq));
    check({name, ".out_pa"}, 64'(outRsp.pagePA), 64'(trsp.pagePA));
    check({name, ".out_tag"}, 64'(outRsp.tag), 64'(tag));
    check({name, ".out_mc"}, 64'(outRsp.mayCache), 64'(trsp.mayCache));
    check({name, ".out_err"}, 64'(outRsp.error), 64'(trsp.error));
    tick();
    check({name, ".out_drop"}, 64'(outValid), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    tlbReqRdy   = 1'b0;
    tlbRspValid = 1'b0;
    tlbRsp      = '0;
    outRdy      = 1'b1;
    drive_head();

    // ---- Reset state ----
    tick();
    tick();
    reset_n = 1'b1;
    settle();
    check("rst.out_valid", 64'(outValid), 64'd0);
    check("rst.req_en", 64'(tlbReqEn), 64'd0);
    check("rst.ins", 64'({en_insert_4kb, en_insert_2mb}), 64'd0);
    check("rst.stats", 64'(statHits | statMisses | statFaults), 64'd0);
    check("rst.deq", 64'(lkpDeq), 64'd0);

    // ---- Hit stream: 8 hits, one per cycle ----
    for (int i = 0; i < 8; i++)
      push(mk_req(36'h100 + 36'(i), 8'(i)), 8'hA0 + 8'(i), mk_rsp(28'h200 + 28'(i), 1'b0, 1'b0, 1'b0));
    settle();
    for (int i = 0; i < 8; i++) begin
      check("hit.deq", 64'(lkpDeq), 64'd1);
      tick();
      check("hit.valid", 64'(outValid), 64'd1);
      check("hit.va", 64'(outReq.pageVA), 64'h100 + 64'(i));
      check("hit.opq", 64'(outOpaque), 64'hA0 + 64'(i));
      check("hit.pa", 64'(outRsp.pagePA), 64'h200 + 64'(i));
      check("hit.tag", 64'(outRsp.tag), 64'(i));
      check("hit.maycache", 64'(outRsp.mayCache), 64'd1);
      check("hit.no_tlb", 64'(tlbReqEn), 64'd0);
    end
    check("hit.deq_done", 64'(lkpDeq), 64'd0);
    tick();
    check("hit.drain", 64'(outValid), 64'd0);
    check("hit.stat", 64'(statHits), 64'd8);
    check("hit.no_miss", 64'(statMisses), 64'd0);

    // ---- Misses: 4KB, 2MB, non-cacheable, fault ----
    run_miss("m4k", 36'h12345, 8'h11, 8'h5A, mk_rsp(28'h0ABCD, 1'b0, 1'b0, 1'b1), 3, 10, 1'b1, 1'b0);
    check("m4k.stat", 64'(statMisses), 64'd1);
    run_miss("m2m", 36'h00400, 8'h12, 8'h6B, mk_rsp(28'h01200, 1'b0, 1'b1, 1'b1), 0, 2, 1'b0, 1'b1);
    run_miss("mnc", 36'h00777, 8'h13, 8'h7C, mk_rsp(28'h03333, 1'b0, 1'b0, 1'b0), 1, 1, 1'b0, 1'b0);
    run_miss("flt", 36'h0DEAD, 8'h14, 8'h8D, mk_rsp(28'h04444, 1'b1, 1'b0, 1'b1), 0, 0, 1'b0, 1'b0);
    check("miss.stat_misses", 64'(statMisses), 64'd4);
    check("miss.stat_faults", 64'(statFaults), 64'd1);
    check("miss.stat_hits", 64'(statHits), 64'd8);

    // ---- Ordering under backpressure: hit A, miss M, hit B ----
    outRdy = 1'b0;
    push(mk_req(36'h300, 8'h21), 8'hC1, mk_rsp(28'h0300, 1'b0, 1'b0, 1'b1));
    push(mk_req(36'h301, 8'h22), 8'hC2, mk_rsp(28'h0, 1'b1, 1'b0, 1'b0));
    push(mk_req(36'h302, 8'h23), 8'hC3, mk_rsp(28'h0302, 1'b0, 1'b0, 1'b1));
    settle();
    check("bp.deq_a", 64'(lkpDeq), 64'd1);
    tick();
    check("bp.a_valid", 64'(outValid), 64'd1);
    check("bp.a_va", 64'(outReq.pageVA), 64'h300);
    check("bp.deq_m_stalled", 64'(lkpDeq), 64'd1);
    tick();
    check("bp.hold_b", 64'(lkpDeq), 64'd0);
    check("bp.req_en", 64'(tlbReqEn), 64'd1);
    tlbReqRdy = 1'b1;
    tick();
    tlbReqRdy   = 1'b0;
    tlbRspValid = 1'b1;
    tlbRsp      = mk_rsp(28'h0777, 1'b0, 1'b0, 1'b1);
    tick();
    tlbRspValid = 1'b0;
    tlbRsp      = '0;
    check("bp.ins4k", 64'(en_insert_4kb), 64'd1);
    for (int k = 0; k < 16; k++) begin
      check("bp.stall_valid", 64'(outValid), 64'd1);
      check("bp.stall_va", 64'(outReq.pageVA), 64'h300);
      check("bp.stall_deq", 64'(lkpDeq), 64'd0);
      tick();
    end
    outRdy = 1'b1;
    settle();
    check("bp.out_deq", 64'(lkpDeq), 64'd0);
    tick();
    check("bp.m_valid", 64'(outValid), 64'd1);
    check("bp.m_va", 64'(outReq.pageVA), 64'h301);
    check("bp.m_pa", 64'(outRsp.pagePA), 64'h0777);
    check("bp.m_opq", 64'(outOpaque), 64'hC2);
    check("bp.deq_b", 64'(lkpDeq), 64'd1);
    tick();
    check("bp.b_valid", 64'(outValid), 64'd1);
    check("bp.b_va", 64'(outReq.pageVA), 64'h302);
    check("bp.b_pa", 64'(outRsp.pagePA), 64'h0302);
    tick();
    check("bp.drain", 64'(outValid), 64'd0);
    check("bp.stat_hits", 64'(statHits), 64'd10);
    check("bp.stat_misses", 64'(statMisses), 64'd5);

    // ---- Reset while waiting on the shared TLB ----
    push(mk_req(36'h555, 8'h31), 8'hD1, mk_rsp(28'h0, 1'b1, 1'b0, 1'b0));
    settle();
    tick();
    check("rw.req_en", 64'(tlbReqEn), 64'd1);
    tlbReqRdy = 1'b1;
    tick();
    tlbReqRdy = 1'b0;
    reset_n   = 1'b0;
    tick();
    reset_n   = 1'b1;
    settle();
    check("rw.out_valid", 64'(outValid), 64'd0);
    check("rw.req_en", 64'(tlbReqEn), 64'd0);
    check("rw.stat_hits", 64'(statHits), 64'd0);
    check("rw.stat_misses", 64'(statMisses), 64'd0);
    check("rw.stat_faults", 64'(statFaults), 64'd0);
    tlbRspValid = 1'b1;
    tlbRsp      = mk_rsp(28'h0999, 1'b0, 1'b0, 1'b1);
    tick();
    tlbRspValid = 1'b0;
    tlbRsp      = '0;
    check("rw.late_no_ins", 64'({en_insert_4kb, en_insert_2mb}), 64'd0);
    tick();
    check("rw.late_no_out", 64'(outValid), 64'd0);
    check("rw.late_no_req", 64'(tlbReqEn), 64'd0);
    push(mk_req(36'h600, 8'h41), 8'hE1, mk_rsp(28'h0600, 1'b0, 1'b0, 1'b0));
    settle();
    check("rw.hit_deq", 64'(lkpDeq), 64'd1);
    tick();
    check("rw.hit_valid", 64'(outValid), 64'd1);
    check("rw.hit_va", 64'(outReq.pageVA), 64'h600);
    check("rw.hit_stat", 64'(statHits), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
